// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: phase accumulator, oversample counter, glitch-free rate switching.
// Optional custom increment path is built only when BAUDGEN_CUSTOM_EN is defined.
module baud_gen_frac #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       baud_sel,
  input  logic             cfg_use_custom,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_load,
  input  logic             sync_rx,
  output logic             rx_tick,
  output logic             rx_mid,
  output logic             tx_tick,
  output logic             rate_busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

  // INC = round(baud * OVERSAMPLE * 2^ACC_W / CLK_FREQ), evaluated in 64 bits at elaboration
  function automatic logic [ACC_W-1:0] calc_inc(input logic [63:0] baud);
    logic [63:0] num;
    num = (baud * 64'(OVERSAMPLE)) << ACC_W;
    return ACC_W'((num + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ));
  endfunction

  localparam logic [ACC_W-1:0] INC_1200   = calc_inc(64'd1200);
  localparam logic [ACC_W-1:0] INC_2400   = calc_inc(64'd2400);
  localparam logic [ACC_W-1:0] INC_4800   = calc_inc(64'd4800);
  localparam logic [ACC_W-1:0] INC_9600   = calc_inc(64'd9600);
  localparam logic [ACC_W-1:0] INC_19200  = calc_inc(64'd19200);
  localparam logic [ACC_W-1:0] INC_38400  = calc_inc(64'd38400);
  localparam logic [ACC_W-1:0] INC_57600  = calc_inc(64'd57600);
  localparam logic [ACC_W-1:0] INC_115200 = calc_inc(64'd115200);

  typedef struct packed {
    logic [2:0]       sel;
`ifdef BAUDGEN_CUSTOM_EN
    logic             custom;
    logic [ACC_W-1:0] inc;
`endif
  } rate_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  function automatic rate_t rate_default();
    rate_t r;
    r     = '0;
    r.sel = 3'd3;
    return r;
  endfunction

  state_t           state_q, state_d;
  rate_t            active_q, active_d;
  rate_t            pend_q, pend_d;
  rate_t            load_rate;
  logic [ACC_W-1:0] table_inc;
  logic [ACC_W-1:0] active_inc;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W:0]   sum;
  logic             carry;

  always_comb begin
    load_rate     = '0;
    load_rate.sel = baud_sel;
`ifdef BAUDGEN_CUSTOM_EN
    load_rate.custom = cfg_use_custom;
    load_rate.inc    = cfg_inc;
`endif
  end

`ifndef BAUDGEN_CUSTOM_EN
  logic unused_custom;
  assign unused_custom = cfg_use_custom ^ (^cfg_inc);
`endif

  always_comb begin
    table_inc = INC_9600;
    case (active_q.sel)
      3'd0: table_inc = INC_1200;
      3'd1: table_inc = INC_2400;
      3'd2: table_inc = INC_4800;
      3'd3: table_inc = INC_9600;
      3'd4: table_inc = INC_19200;
      3'd5: table_inc = INC_38400;
      3'd6: table_inc = INC_57600;
      3'd7: table_inc = INC_115200;
    endcase
  end

`ifdef BAUDGEN_CUSTOM_EN
  assign active_inc = active_q.custom ? active_q.inc : table_inc;
`else
  assign active_inc = table_inc;
`endif

  // cfg_load and sync_rx are single-cycle strobes with no back-pressure: each
  // cycle they are high counts as one request, sampled on the rising edge.
  // A rate request while running is parked in pend_q and only becomes active
  // on the cycle after the tx_tick that closes the current bit.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (!en) begin
      state_d = ST_IDLE;
      if (cfg_load) begin
        active_d = load_rate;
        pend_d   = load_rate;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          if (cfg_load) begin
            active_d = load_rate;
            pend_d   = load_rate;
          end
        end
        ST_RUN: begin
          if (cfg_load) begin
            pend_d  = load_rate;
            state_d = ST_PEND;
          end
        end
        ST_PEND: begin
          if (cfg_load) pend_d = load_rate;
          if (tx_tick) begin
            active_d = cfg_load ? load_rate : pend_q;
            state_d  = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      active_q <= rate_default();
      pend_q   <= rate_default();
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pend_q   <= pend_d;
    end
  end

  assign rate_busy = (state_q == ST_PEND);

  assign sum   = {1'b0, acc_q} + {1'b0, active_inc};
  assign carry = sum[ACC_W];

  // Tick outputs are registered from the adder carry; a sync strobe wins over a carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      rx_tick <= 1'b0;
      rx_mid  <= 1'b0;
      tx_tick <= 1'b0;
    end else if (!en || sync_rx) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      rx_tick <= 1'b0;
      rx_mid  <= 1'b0;
      tx_tick <= 1'b0;
    end else begin
      acc_q   <= sum[ACC_W-1:0];
      rx_tick <= carry;
      rx_mid  <= carry && (cnt_q == CNT_MID);
      tx_tick <= carry && (cnt_q == CNT_LAST);
      if (carry) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Testbench for baud_gen_frac: per-cycle reference model, rate table vectors, hand-written corner sequences.
`timescale 1ns/1ps
module tb_baud_gen_frac;
  localparam int unsigned CLK_FREQ = 50000000;
  localparam int unsigned OS       = 16;
  localparam int unsigned ACC_W    = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [2:0]       baud_sel = 3'd0;
  logic             cfg_use_custom = 1'b0;
  logic [ACC_W-1:0] cfg_inc = '0;
  logic             cfg_load = 1'b0;
  logic             sync_rx = 1'b0;
  logic             rx_tick, rx_mid, tx_tick, rate_busy;

  baud_gen_frac #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .baud_sel(baud_sel),
    .cfg_use_custom(cfg_use_custom), .cfg_inc(cfg_inc), .cfg_load(cfg_load),
    .sync_rx(sync_rx), .rx_tick(rx_tick), .rx_mid(rx_mid), .tx_tick(tx_tick),
    .rate_busy(rate_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      if (n_fail >= 40) report();
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
      if (n_fail >= 40) report();
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned bauds [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};

  function automatic longint unsigned spec_inc(input int sel);
    longint unsigned num;
    num = 64'(bauds[sel]) * 64'(OS) * (64'd1 << ACC_W);
    return (num + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
  endfunction

  function automatic longint unsigned requested_inc();
`ifdef BAUDGEN_CUSTOM_EN
    if (cfg_use_custom) return 64'(cfg_inc);
`endif
    return spec_inc(int'(baud_sel));
  endfunction

  // Phase is kept as an unwrapped running total; a tick is due whenever its
  // integer number of full turns advances.
  longint unsigned m_phase = 0;
  longint unsigned m_inc = 0;
  longint unsigned m_pend_inc = 0;
  int  m_ticks = 0;
  bit  m_pend = 0;
  bit  m_idle = 1;
  bit  e_rx = 0, e_mid = 0, e_tx = 0;

  always @(posedge clk) begin
    bit prev_tx;
    longint unsigned turns;
    prev_tx = e_tx;
    if (rst) begin
      m_phase = 0; m_ticks = 0; m_inc = spec_inc(3); m_pend = 0; m_idle = 1;
      e_rx = 0; e_mid = 0; e_tx = 0;
    end else if (!en) begin
      m_phase = 0; m_ticks = 0; m_pend = 0; m_idle = 1;
      e_rx = 0; e_mid = 0; e_tx = 0;
      if (cfg_load) m_inc = requested_inc();
    end else begin
      if (sync_rx) begin
        m_phase = 0; m_ticks = 0;
        e_rx = 0; e_mid = 0; e_tx = 0;
      end else begin
        turns   = m_phase >> ACC_W;
        m_phase = m_phase + m_inc;
        e_rx    = (m_phase >> ACC_W) != turns;
        e_mid   = e_rx && ((m_ticks % OS) == OS / 2 - 1);
        e_tx    = e_rx && ((m_ticks % OS) == OS - 1);
        if (e_rx) m_ticks++;
      end
      if (m_idle) begin
        if (cfg_load) m_inc = requested_inc();
        m_idle = 0;
      end else if (m_pend && prev_tx) begin
        m_inc  = cfg_load ? requested_inc() : m_pend_inc;
        m_pend = 0;
      end else if (cfg_load) begin
        m_pend_inc = requested_inc();
        m_pend     = 1;
      end
    end
  end

  // ---------------- scoreboard: every cycle against the model ----------------
  always @(posedge clk) begin
    #1;
    n_cmp++;
    if ({rx_tick, rx_mid, tx_tick, rate_busy} !== {e_rx, e_mid, e_tx, m_pend}) begin
      n_fail++;
      $display("FAIL cycle_outputs: got rx/mid/tx/busy=%b expected %b (cycle %0d)",
               {rx_tick, rx_mid, tx_tick, rate_busy}, {e_rx, e_mid, e_tx, m_pend}, cyc);
      if (n_fail >= 40) report();
    end
  end

  initial begin
    #2000000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    report();
  end

  // ---------------- driver tasks ----------------
  task automatic drive_load(input logic [2:0] s, input logic cus, input logic [ACC_W-1:0] ci);
    @(negedge clk);
    baud_sel = s; cfg_use_custom = cus; cfg_inc = ci; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic pulse_sync(output int c0);
    @(negedge clk);
    sync_rx = 1'b1;
    c0 = cyc;
    @(negedge clk);
    sync_rx = 1'b0;
  endtask

  // which: 0 = rx_tick, 1 = tx_tick
  task automatic wait_tick(input int which, output int c, input int budget);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if ((which == 0) ? rx_tick : tx_tick) begin
        c = cyc;
        break;
      end
    end
    n_cmp++;
    if (c < 0) begin
      n_fail++;
      $display("FAIL tick_timeout: no %s within %0d cycles got none expected one", (which == 0) ? "rx_tick" : "tx_tick", budget);
    end
  endtask

  task automatic restart_at(input logic [2:0] s, input logic cus, input logic [ACC_W-1:0] ci, output int c0);
    @(negedge clk);
    en = 1'b0;
    drive_load(s, cus, ci);
    en = 1'b1;
    c0 = cyc;
  endtask

  typedef struct {
    logic [2:0] sel;
    int first;
    int lo;
    int hi;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int c0, c1, c2, c3, t1, k, mid_k, tx_k, quiet;

    vecs[0] = '{3'd0, 2605, 2604, 2605};
    vecs[1] = '{3'd1, 1303, 1302, 1303};
    vecs[2] = '{3'd2,  652,  651,  652};
    vecs[3] = '{3'd3,  326,  325,  326};
    vecs[4] = '{3'd4,  163,  162,  163};
    vecs[5] = '{3'd5,   82,   81,   82};
    vecs[6] = '{3'd6,   55,   54,   55};
    vecs[7] = '{3'd7,   28,   27,   28};

    // reset state, with en already high
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_tick", rx_tick, 0);
    check("reset_rx_mid", rx_mid, 0);
    check("reset_tx_tick", tx_tick, 0);
    check("reset_rate_busy", rate_busy, 0);
    en = 1'b0;
    rst = 1'b0;

    // table vectors: idle load applies at once, first tick after a full period
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = 1'b0;
      drive_load(vecs[i].sel, 1'b0, '0);
      check("idle_load_busy", rate_busy, 0);
      en = 1'b1;
      c0 = cyc;
      wait_tick(0, c1, 3000);
      check("table_first_rx", c1 - c0, vecs[i].first);
      wait_tick(0, c2, 3000);
      check_rng("table_rx_interval", c2 - c1, vecs[i].lo, vecs[i].hi);
    end

    // switch to 115200 mid-bit
    restart_at(3'd3, 1'b0, '0, c0);
    repeat ($urandom_range(300, 1500)) @(negedge clk);
    drive_load(3'd7, 1'b0, '0);
    check("pend_busy_after_load", rate_busy, 1);
    wait_tick(1, t1, 6000);
    check("pend_busy_at_tx", rate_busy, 1);
    @(posedge clk); #1;
    check("pend_busy_after_tx", rate_busy, 0);
    wait_tick(0, c1, 100);
    wait_tick(0, c2, 100);
    wait_tick(0, c3, 100);
    check_rng("fast_rx_interval_a", c2 - c1, 27, 28);
    check_rng("fast_rx_interval_b", c3 - c2, 27, 28);

    // two loads in one pending window: last wins
    restart_at(3'd3, 1'b0, '0, c0);
    repeat ($urandom_range(300, 1500)) @(negedge clk);
    drive_load(3'd5, 1'b0, '0);
    repeat (100) @(negedge clk);
    drive_load(3'd1, 1'b0, '0);
    check("double_load_busy", rate_busy, 1);
    wait_tick(1, t1, 6000);
    wait_tick(0, c1, 3000);
    wait_tick(0, c2, 3000);
    wait_tick(0, c3, 3000);
    check_rng("last_wins_interval_a", c2 - c1, 1302, 1303);
    check_rng("last_wins_interval_b", c3 - c2, 1302, 1303);

    // sync at arbitrary phase: full period, mid on 8th, tx on 16th
    restart_at(3'd3, 1'b0, '0, c0);
    repeat ($urandom_range(100, 700)) @(negedge clk);
    pulse_sync(c0);
    mid_k = 0; tx_k = 0;
    for (k = 1; k <= 16; k++) begin
      wait_tick(0, c1, 400);
      if (k == 1) check("sync_first_rx", c1 - (c0 + 1), 326);
      if (rx_mid && mid_k == 0) mid_k = k;
      if (tx_tick && tx_k == 0) tx_k = k;
    end
    check("sync_mid_index", mid_k, 8);
    check("sync_tx_index", tx_k, 16);
    wait_tick(1, t1, 6000);
    check_rng("tx_interval_9600", t1 - c1, 5208, 5209);

    // sync landing on a carry edge suppresses that tick
    pulse_sync(c0);
    while (cyc < c0 + 326) @(negedge clk);
    sync_rx = 1'b1;
    @(posedge clk); #1;
    check("sync_suppress_rx", rx_tick, 0);
    @(negedge clk);
    sync_rx = 1'b0;
    wait_tick(0, c1, 400);
    check("sync_suppress_next", c1 - (c0 + 327), 326);

    // en low for 1000 cycles
    @(negedge clk);
    en = 1'b0;
    quiet = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (rx_tick || rx_mid || tx_tick) quiet++;
    end
    check("idle_no_ticks", quiet, 0);
    @(negedge clk);
    en = 1'b1;
    c0 = cyc;
    wait_tick(0, c1, 400);
    check("en_rise_first_rx", c1 - c0, 326);

    // reset during a pending change discards it
    drive_load(3'd7, 1'b0, '0);
    check("rst_pend_busy", rate_busy, 1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy_cleared", rate_busy, 0);
    rst = 1'b0;
    c0 = cyc;
    wait_tick(0, c1, 400);
    check("rst_first_rx", c1 - c0, 326);
    wait_tick(0, c2, 400);
    check_rng("rst_rate_9600", c2 - c1, 325, 326);

`ifdef BAUDGEN_CUSTOM_EN
    restart_at(3'd3, 1'b1, 24'h100000, c0);
    wait_tick(0, c1, 100);
    check("custom_first_rx", c1 - c0, 16);
    wait_tick(0, c2, 100);
    check("custom_rx_interval", c2 - c1, 16);
    wait_tick(1, t1, 600);
    wait_tick(1, c3, 600);
    check("custom_tx_interval", c3 - t1, 256);
    restart_at(3'd3, 1'b1, 24'h000000, c0);
    quiet = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (rx_tick || tx_tick) quiet++;
    end
    check("custom_zero_no_ticks", quiet, 0);
    drive_load(3'd0, 1'b1, 24'h100000);
    check("custom_zero_pend_busy", rate_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    wait_tick(0, c1, 400);
    check("custom_rst_first_rx", c1 - c0, 326);
    wait_tick(0, c2, 400);
    check_rng("custom_rst_rate_9600", c2 - c1, 325, 326);
`else
    restart_at(3'd3, 1'b1, 24'h100000, c0);
    wait_tick(0, c1, 400);
    check("custom_ignored_first_rx", c1 - c0, 326);
`endif

    // randomized traffic, judged cycle by cycle by the model
    restart_at(3'd6, 1'b0, '0, c0);
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 3))
        0: drive_load(3'($urandom_range(4, 7)), 1'($urandom_range(0, 1)),
                      ACC_W'($urandom_range(32'h40000, 32'h200000)));
        1: pulse_sync(c0);
        2: begin
          @(negedge clk);
          en = 1'b0;
          repeat ($urandom_range(1, 40)) @(negedge clk);
          en = 1'b1;
        end
        default: ;
      endcase
      repeat ($urandom_range(20, 400)) @(negedge clk);
    end

    report();
  end

endmodule
